uartprobe_uart_rx: RTL and testbench

Serial UART receiver that feeds the probe's command FSM through the uart wrapper's byte-level rx_valid/rx_data/rx_ready interface. It samples the asynchronous uart_rx pin, frames 8N1 characters, and presents each received byte on a holding register until the consumer accepts it. It also reports framing errors and overruns as single-cycle pulses for status logging.

---
 rtl/uartprobe_pkg.sv | 21 ++
 rtl/uartprobe_sync.sv | 26 ++
 rtl/uartprobe_uart_rx.sv | 169 ++++++++++++++++
 tb/tb_uartprobe_uart_rx.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uartprobe_pkg.sv
// Shared types and constants for the probe's UART receive path.
package uartprobe_pkg;

    localparam int UART_DATA_BITS         = 8;
    localparam int CYCLES_PER_BIT_DEFAULT = 868;   // 100 MHz / 115200 baud

    localparam logic [2:0] RX_ST_IDLE      = 3'd0;
    localparam logic [2:0] RX_ST_START     = 3'd1;
    localparam logic [2:0] RX_ST_DATA      = 3'd2;
    localparam logic [2:0] RX_ST_STOP      = 3'd3;
    localparam logic [2:0] RX_ST_WAIT_IDLE = 3'd4;

    typedef enum logic [2:0] {
        RX_IDLE      = RX_ST_IDLE,
        RX_START     = RX_ST_START,
        RX_DATA      = RX_ST_DATA,
        RX_STOP      = RX_ST_STOP,
        RX_WAIT_IDLE = RX_ST_WAIT_IDLE
    } rx_state_t;

endpackage

// File: rtl/uartprobe_sync.sv
// Generic two-flop synchroniser for signals crossing into clk.
// The reset value lets idle-high lines (uart) and idle-low lines (gpi) share it.
module uartprobe_sync #(
    parameter int              WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             areset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two back-to-back flops; only q is safe to use downstream.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uartprobe_uart_rx.sv
// 8N1 UART receiver with a single-byte holding register and valid/ready handoff.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | hunting for a low line (start bit edge)
// START      | waiting to mid start bit; high there means a glitch
// DATA       | sampling 8 data bits LSB first at bit centres
// STOP       | sampling stop bit; deliver, overrun or framing error
// WAIT_IDLE  | after framing error, wait for a full idle stretch of high line
module uartprobe_uart_rx
    import uartprobe_pkg::*;
#(
    parameter int CYCLES_PER_BIT = CYCLES_PER_BIT_DEFAULT,
    parameter int IDLE_HIGH_BITS = 1
) (
    input  logic                      clk,
    input  logic                      areset,
    input  logic                      uart_rx,
    output logic                      rx_valid,
    output logic [UART_DATA_BITS-1:0] rx_data,
    input  logic                      rx_ready,
    output logic                      rx_frame_err,
    output logic                      rx_overrun,
    output logic                      rx_busy
);

    localparam int CW          = $clog2(CYCLES_PER_BIT);
    localparam int IDLE_CYCLES = IDLE_HIGH_BITS * CYCLES_PER_BIT;
    localparam int IW          = $clog2(IDLE_CYCLES);

    localparam logic [CW-1:0] CNT_HALF  = CW'(CYCLES_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(CYCLES_PER_BIT - 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);
    localparam logic [2:0]    BIT_LAST  = 3'(UART_DATA_BITS - 1);

    logic                      line;
    rx_state_t                 state, state_nxt;
    logic [CW-1:0]             cnt, cnt_nxt;
    logic [IW-1:0]             idle_cnt, idle_cnt_nxt;
    logic [2:0]                bit_idx, bit_idx_nxt;
    logic [UART_DATA_BITS-1:0] shift_reg, shift_nxt;
    logic [UART_DATA_BITS-1:0] data_nxt;
    logic                      valid_nxt;
    logic                      ferr_nxt;
    logic                      ovr_nxt;

    uartprobe_sync #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk    (clk),
        .areset (areset),
        .d      (uart_rx),
        .q      (line)
    );

    assign rx_busy = (state != RX_IDLE);

    // State, timers, shifter and the output holding register.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state        <= RX_IDLE;
            cnt          <= '0;
            idle_cnt     <= '0;
            bit_idx      <= '0;
            shift_reg    <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            idle_cnt     <= idle_cnt_nxt;
            bit_idx      <= bit_idx_nxt;
            shift_reg    <= shift_nxt;
            rx_data      <= data_nxt;
            rx_valid     <= valid_nxt;
            rx_frame_err <= ferr_nxt;
            rx_overrun   <= ovr_nxt;
        end
    end

    // Next-state, bit-centre sampling and handshake decisions.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        idle_cnt_nxt = idle_cnt;
        bit_idx_nxt  = bit_idx;
        shift_nxt    = shift_reg;
        data_nxt     = rx_data;
        valid_nxt    = rx_valid;
        ferr_nxt     = 1'b0;
        ovr_nxt      = 1'b0;

        if (rx_valid && rx_ready) begin
            valid_nxt = 1'b0;
        end

        case (state)
            RX_IDLE: begin
                if (!line) begin
                    state_nxt = RX_START;
                    cnt_nxt   = CNT_HALF;
                end
            end
            RX_START: begin
                if (cnt == '0) begin
                    if (line) begin
                        state_nxt = RX_IDLE;
                    end else begin
                        state_nxt   = RX_DATA;
                        bit_idx_nxt = '0;
                        cnt_nxt     = CNT_FULL;
                    end
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt == '0) begin
                    shift_nxt[bit_idx] = line;
                    cnt_nxt            = CNT_FULL;
                    if (bit_idx == BIT_LAST) begin
                        state_nxt   = RX_STOP;
                        bit_idx_nxt = '0;
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt == '0) begin
                    if (line) begin
                        // Leaving mid stop bit lets the next start edge be caught with no gap.
                        state_nxt = RX_IDLE;
                        if (!rx_valid || rx_ready) begin
                            data_nxt  = shift_reg;
                            valid_nxt = 1'b1;
                        end else begin
                            ovr_nxt = 1'b1;
                        end
                    end else begin
                        ferr_nxt     = 1'b1;
                        state_nxt    = RX_WAIT_IDLE;
                        idle_cnt_nxt = IDLE_LAST;
                    end
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            RX_WAIT_IDLE: begin
                if (!line) begin
                    idle_cnt_nxt = IDLE_LAST;
                end else if (idle_cnt == '0) begin
                    state_nxt = RX_IDLE;
                end else begin
                    idle_cnt_nxt = idle_cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = RX_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uartprobe_uart_rx.sv
// Directed bench for uartprobe_uart_rx at 16 clocks per bit.
module tb_uartprobe_uart_rx;

    localparam int CPB = 16;

    logic       clk;
    logic       areset;
    logic       uart_rx;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       rx_frame_err;
    logic       rx_overrun;
    logic       rx_busy;

    int checks;
    int errors;
    int cyc;
    int start_cyc;

    int valid_rises, valid_cycles, rise_cyc;
    logic [7:0] rise_data;
    int ferr_cycles, ovr_cycles, ovr_cyc, both_cycles;
    logic valid_q;

    uartprobe_uart_rx #(
        .CYCLES_PER_BIT (CPB),
        .IDLE_HIGH_BITS (1)
    ) dut (
        .clk          (clk),
        .areset       (areset),
        .uart_rx      (uart_rx),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .rx_frame_err (rx_frame_err),
        .rx_overrun   (rx_overrun),
        .rx_busy      (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor sampled mid-cycle.
    always @(negedge clk) begin
        if (rx_valid && !valid_q) begin
            valid_rises++;
            rise_cyc  = cyc;
            rise_data = rx_data;
        end
        if (rx_valid) valid_cycles++;
        if (rx_frame_err) ferr_cycles++;
        if (rx_overrun) begin
            ovr_cycles++;
            ovr_cyc = cyc;
        end
        if (rx_frame_err && rx_overrun) both_cycles++;
        valid_q = rx_valid;
    end

    task automatic clear_mon();
        valid_rises  = 0;
        valid_cycles = 0;
        ferr_cycles  = 0;
        ovr_cycles   = 0;
        both_cycles  = 0;
        rise_cyc     = 0;
        ovr_cyc      = 0;
        rise_data    = 8'h00;
    endtask

    // Caller sits just after a posedge; each bit lasts CPB cycles, line left at stop level.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] frame;
        frame     = {stop_bit, b, 1'b0};
        start_cyc = cyc;
        for (int i = 0; i < 10; i++) begin
            uart_rx = frame[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
        checks++;
        if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", rx_data); end
        checks++;
        if (rx_frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b want 0", rx_frame_err); end
        checks++;
        if (rx_overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b want 0", rx_overrun); end
        checks++;
        if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", rx_busy); end
        checks++;
        areset = 1'b0;
        idle_cycles(10);
        if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b want 0", rx_busy); end
        checks++;
    endtask

    task automatic test_single_byte();
        int lat;
        rx_ready = 1'b1;
        clear_mon();
        send_frame(8'hA5, 1'b1);
        idle_cycles(10);
        lat = rise_cyc - start_cyc;
        if (valid_rises !== 1) begin errors++; $display("FAIL single_rises: got %0d want 1", valid_rises); end
        checks++;
        if (valid_cycles !== 1) begin errors++; $display("FAIL single_width: got %0d want 1", valid_cycles); end
        checks++;
        if (rise_data !== 8'hA5) begin errors++; $display("FAIL single_data: got %h want a5", rise_data); end
        checks++;
        if (lat < 154 || lat > 156) begin errors++; $display("FAIL single_latency: got %0d want 155+-1", lat); end
        checks++;
        if (ferr_cycles + ovr_cycles !== 0) begin errors++; $display("FAIL single_err_pulses: got %0d want 0", ferr_cycles + ovr_cycles); end
        checks++;
        if (rx_busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b want 0", rx_busy); end
        checks++;
    endtask

    task automatic test_handshake();
        int bad;
        rx_ready = 1'b0;
        clear_mon();
        send_frame(8'h3C, 1'b1);
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rx_valid !== 1'b1 || rx_data !== 8'h3C) bad++;
        end
        if (bad !== 0) begin errors++; $display("FAIL hold_stable: got %0d bad cycles want 0", bad); end
        checks++;
        @(posedge clk);
        #1;
        rx_ready = 1'b1;
        if (rx_valid !== 1'b1) begin errors++; $display("FAIL hold_before_ready: got %b want 1", rx_valid); end
        checks++;
        @(posedge clk);
        #1;
        if (rx_valid !== 1'b0) begin errors++; $display("FAIL hold_clear: got %b want 0", rx_valid); end
        checks++;
        rx_ready = 1'b0;
    endtask

    task automatic test_overrun();
        int lat;
        rx_ready = 1'b0;
        clear_mon();
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        idle_cycles(10);
        lat = ovr_cyc - start_cyc;
        if (ovr_cycles !== 1) begin errors++; $display("FAIL ovr_pulses: got %0d want 1", ovr_cycles); end
        checks++;
        if (lat < 154 || lat > 156) begin errors++; $display("FAIL ovr_timing: got %0d want 155+-1", lat); end
        checks++;
        if (rx_data !== 8'h11) begin errors++; $display("FAIL ovr_data: got %h want 11", rx_data); end
        checks++;
        if (rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid: got %b want 1", rx_valid); end
        checks++;
        if (valid_rises !== 1) begin errors++; $display("FAIL ovr_rises: got %0d want 1", valid_rises); end
        checks++;
        if (ferr_cycles !== 0) begin errors++; $display("FAIL ovr_ferr: got %0d want 0", ferr_cycles); end
        checks++;
        rx_ready = 1'b1;
        idle_cycles(1);
        rx_ready = 1'b0;
    endtask

    task automatic test_frame_error();
        rx_ready = 1'b1;
        clear_mon();
        send_frame(8'h55, 1'b0);
        uart_rx = 1'b1;
        idle_cycles(CPB);
        send_frame(8'h0F, 1'b1);
        idle_cycles(10);
        if (ferr_cycles !== 1) begin errors++; $display("FAIL ferr_pulses: got %0d want 1", ferr_cycles); end
        checks++;
        if (valid_rises !== 1) begin errors++; $display("FAIL ferr_rises: got %0d want 1", valid_rises); end
        checks++;
        if (rise_data !== 8'h0F) begin errors++; $display("FAIL ferr_next_data: got %h want 0f", rise_data); end
        checks++;
        if (ovr_cycles !== 0) begin errors++; $display("FAIL ferr_ovr: got %0d want 0", ovr_cycles); end
        checks++;
        if (both_cycles !== 0) begin errors++; $display("FAIL ferr_both: got %0d want 0", both_cycles); end
        checks++;
    endtask

    task automatic test_glitch();
        rx_ready = 1'b1;
        clear_mon();
        uart_rx = 1'b0;
        idle_cycles(4);
        uart_rx = 1'b1;
        if (rx_busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_rise: got %b want 1", rx_busy); end
        checks++;
        idle_cycles(30);
        if (rx_busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_fall: got %b want 0", rx_busy); end
        checks++;
        if (valid_rises !== 0) begin errors++; $display("FAIL glitch_valid: got %0d want 0", valid_rises); end
        checks++;
    endtask

    task automatic test_reset_midframe();
        rx_ready = 1'b0;
        send_frame(8'h77, 1'b1);
        idle_cycles(4);
        uart_rx = 1'b0;
        idle_cycles(CPB);
        uart_rx = 1'b1;
        idle_cycles(3 * CPB + CPB / 2);
        areset = 1'b1;
        #1;
        if (rx_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", rx_valid); end
        checks++;
        if (rx_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %h want 00", rx_data); end
        checks++;
        if (rx_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", rx_busy); end
        checks++;
        if (rx_frame_err !== 1'b0 || rx_overrun !== 1'b0) begin
            errors++; $display("FAIL rst_pulses: got %b%b want 00", rx_frame_err, rx_overrun);
        end
        checks++;
        idle_cycles(4);
        areset = 1'b0;
        idle_cycles(6 * CPB);
        rx_ready = 1'b1;
        clear_mon();
        send_frame(8'h81, 1'b1);
        idle_cycles(10);
        if (valid_rises !== 1) begin errors++; $display("FAIL rst_after_rises: got %0d want 1", valid_rises); end
        checks++;
        if (rise_data !== 8'h81) begin errors++; $display("FAIL rst_after_data: got %h want 81", rise_data); end
        checks++;
        if (ferr_cycles + ovr_cycles !== 0) begin errors++; $display("FAIL rst_after_err: got %0d want 0", ferr_cycles + ovr_cycles); end
        checks++;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        cyc      = 0;
        valid_q  = 1'b0;
        areset   = 1'b1;
        uart_rx  = 1'b1;
        rx_ready = 1'b0;
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_single_byte();
        test_handshake();
        test_overrun();
        test_frame_error();
        test_glitch();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
